// File: rtl/pulse_rate_meter.sv
// Heartbeat rate meter: counts accepted pulse edges over WINDOW_SEC time-base periods and reports BPM.
// Define PULSE_DEBOUNCE_EN to filter the synchronized pulse level through a DEBOUNCE_CYC stability counter.
module pulse_rate_meter #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned WINDOW_SEC   = 15,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned BPM_W        = 10,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic             C_100Mhz,
    input  logic             rst_n,
    input  logic             gate_in,
    input  logic             pulse_in,
    output logic [BPM_W-1:0] bpm,
    output logic             bpm_valid,
    output logic             bpm_ovf,
    output logic             window_active
);

    localparam int unsigned MULT   = 60 / WINDOW_SEC;
    localparam int unsigned PROD_W = CNT_W + 7;
    localparam int unsigned SEC_W  = (WINDOW_SEC > 1) ? $clog2(WINDOW_SEC) : 1;

    if ((WINDOW_SEC == 0) || (60 % WINDOW_SEC != 0)) begin : g_bad_window
        $error("pulse_rate_meter: WINDOW_SEC must divide 60");
    end
    if ((CLK_HZ == 0) || (DEBOUNCE_CYC == 0)) begin : g_bad_timing
        $error("pulse_rate_meter: CLK_HZ and DEBOUNCE_CYC must be non-zero");
    end

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        MEASURE   = 2'd1,
        REPORT    = 2'd2
    } state_t;

    // pulse_in is asynchronous: two flops before any logic looks at it.
    logic pulse_s1_q, pulse_s2_q;
    logic pulse_lvl;
    logic pulse_prev_q, pulse_ev_q;
    logic gate_q, gate_prev_q, gate_ev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge C_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            pulse_s1_q   <= 1'b0;
            pulse_s2_q   <= 1'b0;
            pulse_prev_q <= 1'b0;
            pulse_ev_q   <= 1'b0;
            gate_q       <= 1'b0;
            gate_prev_q  <= 1'b0;
        end else begin
            pulse_s1_q   <= pulse_in;
            pulse_s2_q   <= pulse_s1_q;
            pulse_prev_q <= pulse_lvl;
            pulse_ev_q   <= pulse_lvl & ~pulse_prev_q;
            gate_q       <= gate_in;
            gate_prev_q  <= gate_q;
        end
    end

    assign gate_ev = gate_q & ~gate_prev_q;

`ifdef PULSE_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYC + 1);

    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            pulse_acc_q, pulse_acc_d;

    // Any cycle where the input agrees with the accepted level restarts the stability count.
    always_comb begin
        db_cnt_d    = '0;
        pulse_acc_d = pulse_acc_q;
        if (pulse_s2_q != pulse_acc_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYC - 1)) begin
                pulse_acc_d = pulse_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge C_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q    <= '0;
            pulse_acc_q <= 1'b0;
        end else begin
            db_cnt_q    <= db_cnt_d;
            pulse_acc_q <= pulse_acc_d;
        end
    end

    assign pulse_lvl = pulse_acc_q;
`else
    assign pulse_lvl = pulse_s2_q;
`endif

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  pulse_cnt_q, pulse_cnt_d;
    logic [SEC_W-1:0]  sec_cnt_q, sec_cnt_d;
    logic              ovf_flag_q, ovf_flag_d;
    logic [BPM_W-1:0]  bpm_q, bpm_d;
    logic              bpm_ovf_q, bpm_ovf_d;
    logic              bpm_valid_q, bpm_valid_d;

    logic [PROD_W-1:0] product;
    logic [BPM_W-1:0]  bpm_sat;
    logic              bpm_clip;

    assign product = PROD_W'(pulse_cnt_q) * PROD_W'(MULT);

    if (PROD_W > BPM_W) begin : g_clip
        assign bpm_clip = |product[PROD_W-1:BPM_W];
        assign bpm_sat  = bpm_clip ? '1 : product[BPM_W-1:0];
    end else begin : g_no_clip
        assign bpm_clip = 1'b0;
        assign bpm_sat  = BPM_W'(product);
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        sec_cnt_d   = sec_cnt_q;
        ovf_flag_d  = ovf_flag_q;
        bpm_d       = bpm_q;
        bpm_ovf_d   = bpm_ovf_q;
        bpm_valid_d = 1'b0;

        unique case (state_q)
            WAIT_SYNC: begin
                if (gate_ev) begin
                    pulse_cnt_d = '0;
                    sec_cnt_d   = '0;
                    state_d     = MEASURE;
                end
            end
            MEASURE: begin
                if (pulse_ev_q) begin
                    if (pulse_cnt_q == '1) begin
                        ovf_flag_d = 1'b1;
                    end else begin
                        pulse_cnt_d = pulse_cnt_q + CNT_W'(1);
                    end
                end
                // A pulse and the closing gate in the same cycle both land in this window.
                if (gate_ev) begin
                    if (sec_cnt_q == SEC_W'(WINDOW_SEC - 1)) begin
                        state_d = REPORT;
                    end else begin
                        sec_cnt_d = sec_cnt_q + SEC_W'(1);
                    end
                end
            end
            REPORT: begin
                bpm_d       = bpm_sat;
                bpm_ovf_d   = ovf_flag_q | bpm_clip;
                bpm_valid_d = 1'b1;
                pulse_cnt_d = pulse_ev_q ? CNT_W'(1) : '0;
                sec_cnt_d   = '0;
                ovf_flag_d  = 1'b0;
                state_d     = MEASURE;
            end
            default: begin
                state_d = WAIT_SYNC;
            end
        endcase
    end

    always_ff @(posedge C_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_SYNC;
            pulse_cnt_q <= '0;
            sec_cnt_q   <= '0;
            ovf_flag_q  <= 1'b0;
            bpm_q       <= '0;
            bpm_ovf_q   <= 1'b0;
            bpm_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            sec_cnt_q   <= sec_cnt_d;
            ovf_flag_q  <= ovf_flag_d;
            bpm_q       <= bpm_d;
            bpm_ovf_q   <= bpm_ovf_d;
            bpm_valid_q <= bpm_valid_d;
        end
    end

    assign bpm           = bpm_q;
    assign bpm_ovf       = bpm_ovf_q;
    assign bpm_valid     = bpm_valid_q;
    assign window_active = (state_q != WAIT_SYNC);

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Bench for pulse_rate_meter: three instances (nominal, 4-bit counter, 6-bit bpm) share one stimulus stream.
// Per-window expectations go to a scoreboard when the window is driven and are checked on bpm_valid.
`timescale 1ns/1ps
module tb_pulse_rate_meter;

    localparam int WINDOW  = 300;           // 15 gate periods of 20 cycles
    localparam int NWIN    = 8;
    localparam int PAT_LEN = NWIN * WINDOW + 40;
`ifdef PULSE_DEBOUNCE_EN
    localparam int DB    = 4;
    localparam bit DB_ON = 1'b1;
`else
    localparam int DB    = 0;
    localparam bit DB_ON = 1'b0;
`endif

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic gate_in  = 1'b0;
    logic pulse_in = 1'b0;

    always #5 clk = ~clk;

    logic [9:0] bpm_m, bpm_s;
    logic [5:0] bpm_c;
    logic       v_m, v_s, v_c;
    logic       o_m, o_s, o_c;
    logic       wa_m, wa_s, wa_c;

    pulse_rate_meter #(.WINDOW_SEC(15), .CNT_W(8), .BPM_W(10), .DEBOUNCE_CYC(4)) u_main (
        .C_100Mhz(clk), .rst_n(rst_n), .gate_in(gate_in), .pulse_in(pulse_in),
        .bpm(bpm_m), .bpm_valid(v_m), .bpm_ovf(o_m), .window_active(wa_m));
    pulse_rate_meter #(.WINDOW_SEC(15), .CNT_W(4), .BPM_W(10), .DEBOUNCE_CYC(4)) u_sat (
        .C_100Mhz(clk), .rst_n(rst_n), .gate_in(gate_in), .pulse_in(pulse_in),
        .bpm(bpm_s), .bpm_valid(v_s), .bpm_ovf(o_s), .window_active(wa_s));
    pulse_rate_meter #(.WINDOW_SEC(15), .CNT_W(8), .BPM_W(6), .DEBOUNCE_CYC(4)) u_clip (
        .C_100Mhz(clk), .rst_n(rst_n), .gate_in(gate_in), .pulse_in(pulse_in),
        .bpm(bpm_c), .bpm_valid(v_c), .bpm_ovf(o_c), .window_active(wa_c));

    typedef struct {
        int n_reg;           // regular 4-high/4-low pulses starting at call 10
        bit close_pulse;     // pulse_ev lands on the closing gate_ev
        bit report_pulse;    // pulse_ev lands in the REPORT cycle
        bit db_pattern;      // 2-cycle glitch plus an 8-cycle pulse with a 1-cycle dropout
        int exp_n;           // pulses that must be counted in this window
    } win_vec_t;

    typedef struct {
        logic [9:0] bpm_m;
        logic       ovf_m;
        logic [9:0] bpm_s;
        logic       ovf_s;
        logic [5:0] bpm_c;
        logic       ovf_c;
    } exp_t;

    win_vec_t vec [NWIN];
    exp_t     sb [$];
    logic     pat [0:PAT_LEN-1];
    int       n_err   = 0;
    int       n_chk   = 0;
    int       n_valid = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_one(input int n, input int cnt_w, input int bpm_w,
                                      output int b, output bit o);
        int cmax = (1 << cnt_w) - 1;
        int bmax = (1 << bpm_w) - 1;
        int c    = (n > cmax) ? cmax : n;
        int p    = c * (60 / 15);
        b = (p > bmax) ? bmax : p;
        o = (n > cmax) || (p > bmax);
    endfunction

    function automatic exp_t model(input int n);
        exp_t e;
        int   b;
        bit   o;
        model_one(n, 8, 10, b, o);
        e.bpm_m = 10'(b);
        e.ovf_m = o;
        model_one(n, 4, 10, b, o);
        e.bpm_s = 10'(b);
        e.ovf_s = o;
        model_one(n, 8, 6, b, o);
        e.bpm_c = 6'(b);
        e.ovf_c = o;
        return e;
    endfunction

    task automatic add_pulse(input int start, input int len);
        for (int j = 0; j < len; j++) pat[start + j] = 1'b1;
    endtask

    task automatic cyc(input logic p, input logic g);
        @(posedge clk);
        #1;
        pulse_in = p;
        gate_in  = g;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (v_m || v_s || v_c) begin
            n_valid++;
            check("valid_align", 32'({v_m, v_s, v_c}), 32'd7);
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("bpm_main", 32'(bpm_m), 32'(e.bpm_m));
                check("ovf_main", 32'(o_m), 32'(e.ovf_m));
                check("bpm_sat", 32'(bpm_s), 32'(e.bpm_s));
                check("ovf_sat", 32'(o_s), 32'(e.ovf_s));
                check("bpm_clip", 32'(bpm_c), 32'(e.bpm_c));
                check("ovf_clip", 32'(o_c), 32'(e.ovf_c));
            end
        end
    end

    initial begin : stim
        exp_t held;
        int   g;
        vec[0] = '{18, 1'b0, 1'b0, 1'b0, 18};
        vec[1] = '{0,  1'b0, 1'b0, 1'b0, 0};
        vec[2] = '{20, 1'b0, 1'b0, 1'b0, 20};
        vec[3] = '{10, 1'b0, 1'b0, 1'b0, 10};
        vec[4] = '{17, 1'b1, 1'b0, 1'b0, 18};
        vec[5] = '{5,  1'b0, 1'b1, 1'b0, 5};
        vec[6] = '{2,  1'b0, 1'b0, 1'b0, 3};   // plus the pulse caught in the previous REPORT cycle
        vec[7] = '{0,  1'b0, 1'b0, 1'b1, DB_ON ? 1 : 3};

        for (int k = 0; k < PAT_LEN; k++) pat[k] = 1'b0;
        for (int w = 0; w < NWIN; w++) begin
            for (int k = 0; k < vec[w].n_reg; k++) add_pulse(w * WINDOW + 10 + 8 * k, 4);
            if (vec[w].close_pulse)  add_pulse(w * WINDOW + 298 - DB, 4);
            if (vec[w].report_pulse) add_pulse(w * WINDOW + 299 - DB, 4);
            if (vec[w].db_pattern) begin
                add_pulse(w * WINDOW + 20, 2);
                add_pulse(w * WINDOW + 60, 3);
                add_pulse(w * WINDOW + 64, 4);
            end
        end

        // Reset state
        repeat (3) cyc(1'b0, 1'b0);
        check("rst_bpm", 32'(bpm_m), 32'd0);
        check("rst_valid", 32'(v_m), 32'd0);
        check("rst_ovf", 32'(o_m), 32'd0);
        check("rst_active", 32'(wa_m), 32'd0);
        rst_n = 1'b1;

        // Open a window, count 5 pulses, then reset in the middle of it
        for (int i = 0; i < 60; i++) begin
            cyc((i >= 10 && i < 50 && ((i - 10) % 8) < 4) ? 1'b1 : 1'b0, ((i % 20) < 10) ? 1'b1 : 1'b0);
        end
        check("active_mid_window", 32'(wa_m), 32'd1);
        rst_n = 1'b0;
        repeat (2) cyc(1'b0, 1'b0);
        check("midrst_active", 32'({wa_m, wa_s, wa_c}), 32'd0);
        check("midrst_bpm", 32'(bpm_m), 32'd0);
        check("midrst_ovf_valid", 32'({o_m, v_m}), 32'd0);
        rst_n = 1'b1;

        // Three pulses before the time base starts: must not be counted
        for (int i = 0; i < 40; i++) begin
            cyc((i >= 5 && i < 29 && ((i - 5) % 8) < 4) ? 1'b1 : 1'b0, 1'b0);
        end
        check("presync_active", 32'(wa_m), 32'd0);
        check("presync_bpm", 32'(bpm_m), 32'd0);

        // Measurement windows, plus a short tail so the last report appears
        for (int w = 0; w <= NWIN; w++) begin
            for (int i = 0; i < WINDOW; i++) begin
                if (w == NWIN && i >= 20) break;
                if (w < NWIN && i == 0) sb.push_back(model(vec[w].exp_n));
                if (w == 0 && i == 2) check("active_before_gate_ev", 32'(wa_m), 32'd0);
                if (w == 0 && i == 3) check("active_after_gate_ev", 32'(wa_m), 32'd1);
                if (w >= 1 && i == 150) begin
                    held = model(vec[w - 1].exp_n);
                    check("bpm_hold", 32'(bpm_m), 32'(held.bpm_m));
                    check("ovf_hold", 32'(o_m), 32'(held.ovf_m));
                end
                g = w * WINDOW + i;
                cyc(pat[g], ((g % 20) < 10) ? 1'b1 : 1'b0);
            end
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        check("valid_count", 32'(n_valid), 32'(NWIN));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
